alu_mc: RTL

- Parametrised multi-cycle successor to the single-cycle ALU in the RISC-V datapath.
- Adds a registered valid/ready interface and an iterative shift-add multiplier / restoring divider.
- Adds signed and unsigned MUL/DIV variants with defined RISC-V corner-case results.
- Sits between the ID/EX operand latch and the writeback mux; the pipeline stalls on in_ready=0.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_muldiv_iter.sv | 90 +++++++++
 rtl/alu_mc.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: op codes, handshake states and op width.
package alu_pkg;

    localparam int ALU_OP_W = 4;

    typedef enum logic [ALU_OP_W-1:0] {
        OP_SLL  = 4'd0,
        OP_SRA  = 4'd1,
        OP_SRL  = 4'd2,
        OP_MUL  = 4'd3,
        OP_DIV  = 4'd4,
        OP_ADD  = 4'd5,
        OP_SUB  = 4'd6,
        OP_AND  = 4'd7,
        OP_OR   = 4'd8,
        OP_XOR  = 4'd9,
        OP_NOR  = 4'd10,
        OP_SLT  = 4'd11,
        OP_SLTU = 4'd12,
        OP_MULU = 4'd13,
        OP_DIVU = 4'd14,
        OP_RSVD = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned core: shift-add multiplier or restoring divider, one bit per cycle.
// raw_lo/raw_hi present the accumulator value after the current step, so they are final while done=1.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter  int XLEN = 32,
    localparam int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            is_div,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] raw_lo,
    output logic [XLEN-1:0] raw_hi
);

    logic            busy_q, busy_d;
    logic            div_q, div_d;
    logic [SHW-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0] m_q, m_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;

    logic [XLEN:0]   sum;
    logic [XLEN:0]   rem_sh;
    logic [XLEN-1:0] diff;
    logic            sub_ok;

    always_comb begin
        busy_d = busy_q;
        div_d  = div_q;
        cnt_d  = cnt_q;
        m_d    = m_q;
        hi_d   = hi_q;
        lo_d   = lo_q;

        sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
        rem_sh = {hi_q, lo_q[XLEN-1]};
        // A set top bit means the shifted remainder already exceeds any XLEN-bit divisor.
        sub_ok = rem_sh[XLEN] | (rem_sh[XLEN-1:0] >= m_q);
        diff   = rem_sh[XLEN-1:0] - m_q;
        done   = busy_q && (cnt_q == SHW'(XLEN-1));

        if (start) begin
            busy_d = 1'b1;
            div_d  = is_div;
            cnt_d  = '0;
            m_d    = is_div ? b : a;
            hi_d   = '0;
            lo_d   = is_div ? a : b;
        end else if (busy_q) begin
            cnt_d = cnt_q + 1'b1;
            if (div_q) begin
                hi_d = sub_ok ? diff : rem_sh[XLEN-1:0];
                lo_d = {lo_q[XLEN-2:0], sub_ok};
            end else begin
                hi_d = sum[XLEN:1];
                lo_d = {sum[0], lo_q[XLEN-1:1]};
            end
            if (done) begin
                busy_d = 1'b0;
            end
        end

        raw_lo = lo_d;
        raw_hi = hi_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            div_q  <= 1'b0;
            cnt_q  <= '0;
            m_q    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            busy_q <= busy_d;
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            m_q    <= m_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshake and iterative MUL/DIV.
// Define ALU_EARLY_OUT_EN to let trivial MUL/DIV operands complete in one cycle.
//   state | meaning
//   IDLE  | no result held, ready for an op
//   BUSY  | iterative MUL/DIV in progress
//   DONE  | result registers valid, waiting for out_ready
module alu_mc
    import alu_pkg::*;
#(
    parameter  int XLEN = 32,
    localparam int SHW  = $clog2(XLEN)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ALU_OP_W-1:0] alu_op,
    input  logic [XLEN-1:0]     x,
    input  logic [XLEN-1:0]     y,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     result,
    output logic [XLEN-1:0]     result_hi,
    output logic                less,
    output logic                nol,
    output logic                equal,
    output logic                busy
);

    alu_state_e      state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [XLEN-1:0] result_hi_q, result_hi_d;
    logic            less_q, less_d;
    logic            equal_q, equal_d;
    logic            neg_lo_q, neg_lo_d;
    logic            neg_hi_q, neg_hi_d;
    logic            mul_q, mul_d;

    alu_op_e         op;
    logic            accept, start, early;
    logic            is_mul, is_div, iter_op, sgn_op, sx, sy;
    logic [SHW-1:0]  sh;
    logic [XLEN-1:0] mag_x, mag_y;
    logic [XLEN-1:0] sc_lo, sc_hi;
    logic            sc_less;

    logic              core_done;
    logic [XLEN-1:0]   raw_lo, raw_hi;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   fix_lo, fix_hi;

    assign op        = alu_op_e'(alu_op);
    assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == BUSY);
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign less      = less_q;
    assign nol       = ~less_q;
    assign equal     = equal_q;

    always_comb begin
        sh      = y[SHW-1:0];
        is_mul  = (op == OP_MUL) | (op == OP_MULU);
        is_div  = (op == OP_DIV) | (op == OP_DIVU);
        iter_op = is_mul | is_div;
        sgn_op  = (op == OP_MUL) | (op == OP_DIV);
        sx      = sgn_op & x[XLEN-1];
        sy      = sgn_op & y[XLEN-1];
        mag_x   = sx ? -x : x;
        mag_y   = sy ? -y : y;
`ifdef ALU_EARLY_OUT_EN
        early   = iter_op & ((x == '0) | (y == '0) | (is_mul & (y == XLEN'(1))));
`else
        early   = 1'b0;
`endif
        start   = accept & iter_op & ~early;

        sc_lo   = '0;
        sc_hi   = '0;
        sc_less = 1'b0;
        case (op)
            OP_SLL:  sc_lo = x << sh;
            OP_SRA:  sc_lo = $signed(x) >>> sh;
            OP_SRL:  sc_lo = x >> sh;
            OP_ADD:  sc_lo = x + y;
            OP_SUB:  sc_lo = x - y;
            OP_AND:  sc_lo = x & y;
            OP_OR:   sc_lo = x | y;
            OP_XOR:  sc_lo = x ^ y;
            OP_NOR:  sc_lo = ~(x | y);
            OP_SLT: begin
                sc_less = $signed(x) < $signed(y);
                sc_lo   = {{(XLEN-1){1'b0}}, sc_less};
            end
            OP_SLTU: begin
                sc_less = x < y;
                sc_lo   = {{(XLEN-1){1'b0}}, sc_less};
            end
`ifdef ALU_EARLY_OUT_EN
            // Zero operands fall through to the all-zero default.
            OP_MUL, OP_MULU: begin
                if ((x != '0) && (y == XLEN'(1))) begin
                    sc_lo = x;
                    sc_hi = ((op == OP_MUL) && x[XLEN-1]) ? '1 : '0;
                end
            end
            OP_DIV, OP_DIVU: begin
                if (y == '0) begin
                    sc_lo = '1;
                    sc_hi = x;
                end
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        prod_fix = neg_lo_q ? -{raw_hi, raw_lo} : {raw_hi, raw_lo};
        fix_lo   = mul_q ? prod_fix[XLEN-1:0]      : (neg_lo_q ? -raw_lo : raw_lo);
        fix_hi   = mul_q ? prod_fix[2*XLEN-1:XLEN] : (neg_hi_q ? -raw_hi : raw_hi);
    end

    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        less_d      = less_q;
        equal_d     = equal_q;
        neg_lo_d    = neg_lo_q;
        neg_hi_d    = neg_hi_q;
        mul_d       = mul_q;

        if (accept) begin
            equal_d  = (x == y);
            less_d   = sc_less;
            mul_d    = is_mul;
            // Divide by zero keeps the all-ones quotient unsigned-looking.
            neg_lo_d = is_mul ? (sx ^ sy) : ((sx ^ sy) & (y != '0));
            neg_hi_d = is_div & sx;
            if (start) begin
                state_d     = BUSY;
                result_d    = '0;
                result_hi_d = '0;
            end else begin
                state_d     = DONE;
                result_d    = sc_lo;
                result_hi_d = sc_hi;
            end
        end else if ((state_q == BUSY) && core_done) begin
            state_d     = DONE;
            result_d    = fix_lo;
            result_hi_d = fix_hi;
        end else if ((state_q == DONE) && out_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            result_q    <= '0;
            result_hi_q <= '0;
            less_q      <= 1'b0;
            equal_q     <= 1'b0;
            neg_lo_q    <= 1'b0;
            neg_hi_q    <= 1'b0;
            mul_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            less_q      <= less_d;
            equal_q     <= equal_d;
            neg_lo_q    <= neg_lo_d;
            neg_hi_q    <= neg_hi_d;
            mul_q       <= mul_d;
        end
    end

    alu_muldiv_iter #(.XLEN(XLEN)) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .is_div (is_div),
        .a      (mag_x),
        .b      (mag_y),
        .done   (core_done),
        .raw_lo (raw_lo),
        .raw_hi (raw_hi)
    );

endmodule
